// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: MM:SS BCD stopwatch with start/stop, lap freeze, clear and preset keys.
// Optional alarm flag is built only when STOPWATCH_CTRL_ALARM_EN is defined.
module stopwatch_ctrl #(
  parameter int TICK_COUNT = 50000000,
  parameter int PRESET_MIN = 59,
  parameter int ALARM_MIN  = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] key_i,
  output logic [3:0] digit0_o,
  output logic [3:0] digit1_o,
  output logic [3:0] digit2_o,
  output logic [3:0] digit3_o,
  output logic       running_o,
  output logic       lap_active_o,
  output logic       tick_o,
  output logic       alarm_o
);

  // state    | meaning
  // ST_IDLE  | stopped, awaiting start
  // ST_RUN   | prescaler counting, time advancing
  // ST_PAUSE | stopped, partial second retained
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam int PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_COUNT - 1);
  localparam logic [3:0] PRE_MT = 4'(PRESET_MIN / 10);
  localparam logic [3:0] PRE_MU = 4'(PRESET_MIN % 10);

  logic [3:0]      key_s1_q, key_s2_q, key_s3_q;
  logic [3:0]      press;
  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0][3:0] time_q, time_d, time_inc, snap_q, snap_d;
  logic            lap_q, lap_d, tick_q, tick_d, running_q;
  logic            in_run, clr_go, start_go, preset_go;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_s1_q <= 4'hF;
      key_s2_q <= 4'hF;
      key_s3_q <= 4'hF;
    end else begin
      key_s1_q <= key_i;
      key_s2_q <= key_s1_q;
      key_s3_q <= key_s2_q;
    end
  end

  assign press = key_s3_q & ~key_s2_q;

  // Clear is only effective outside RUN; when effective it beats start, which beats preset.
  assign in_run    = (state_q == ST_RUN);
  assign clr_go    = press[2] & ~in_run;
  assign start_go  = press[0] & ~clr_go;
  assign preset_go = press[3] & ~in_run & ~clr_go & ~press[0];

  always_comb begin
    time_inc = time_q;
    if (time_q[0] != 4'd9) begin
      time_inc[0] = time_q[0] + 4'd1;
    end else begin
      time_inc[0] = 4'd0;
      if (time_q[1] != 4'd5) begin
        time_inc[1] = time_q[1] + 4'd1;
      end else begin
        time_inc[1] = 4'd0;
        if (time_q[2] != 4'd9) begin
          time_inc[2] = time_q[2] + 4'd1;
        end else begin
          time_inc[2] = 4'd0;
          time_inc[3] = (time_q[3] == 4'd5) ? 4'd0 : time_q[3] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    time_d  = time_q;
    snap_d  = snap_q;
    lap_d   = lap_q;
    tick_d  = 1'b0;

    if (clr_go)        state_d = ST_IDLE;
    else if (start_go) state_d = in_run ? ST_PAUSE : ST_RUN;

    if (in_run) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    if (tick_q) time_d = time_inc;

    if (clr_go) begin
      time_d  = '0;
      presc_d = '0;
    end else if (preset_go) begin
      time_d  = {PRE_MT, PRE_MU, 4'd0, 4'd0};
      presc_d = '0;
    end

    if (clr_go) begin
      lap_d = 1'b0;
    end else if (press[1]) begin
      lap_d = ~lap_q;
      if (!lap_q) snap_d = time_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      time_q    <= '0;
      snap_q    <= '0;
      lap_q     <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      time_q    <= time_d;
      snap_q    <= snap_d;
      lap_q     <= lap_d;
      tick_q    <= tick_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign digit0_o     = lap_q ? snap_q[0] : time_q[0];
  assign digit1_o     = lap_q ? snap_q[1] : time_q[1];
  assign digit2_o     = lap_q ? snap_q[2] : time_q[2];
  assign digit3_o     = lap_q ? snap_q[3] : time_q[3];
  assign running_o    = running_q;
  assign lap_active_o = lap_q;
  assign tick_o       = tick_q;

`ifdef STOPWATCH_CTRL_ALARM_EN
  localparam logic [3:0] ALM_MT = 4'(ALARM_MIN / 10);
  localparam logic [3:0] ALM_MU = 4'(ALARM_MIN % 10);

  logic adv_q, alarm_q;

  // adv_q marks a cycle whose time value came from counting, so preset never arms the alarm.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adv_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      adv_q <= tick_q & ~clr_go & ~preset_go;
      if (start_go || clr_go)
        alarm_q <= 1'b0;
      else if (adv_q && in_run && (time_q == {ALM_MT, ALM_MU, 8'h00}))
        alarm_q <= 1'b1;
    end
  end

  assign alarm_o = alarm_q;
`else
  assign alarm_o = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with a 4-cycle second.
module tb_stopwatch_ctrl;
  localparam int TC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key = 4'hF;
  logic [3:0] d0, d1, d2, d3;
  logic       running, lap_active, tick, alarm;
  logic [15:0] disp;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int prev;

`ifdef STOPWATCH_CTRL_ALARM_EN
  localparam logic ALM_EXP = 1'b1;
`else
  localparam logic ALM_EXP = 1'b0;
`endif

  assign disp = {d3, d2, d1, d0};

  stopwatch_ctrl #(.TICK_COUNT(TC), .PRESET_MIN(59), .ALARM_MIN(1)) dut (
    .clk_i(clk), .rst_i(rst), .key_i(key),
    .digit0_o(d0), .digit1_o(d1), .digit2_o(d2), .digit3_o(d3),
    .running_o(running), .lap_active_o(lap_active), .tick_o(tick), .alarm_o(alarm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Effect of a press is visible at the negedge this task returns on.
  task automatic press(input logic [3:0] mask);
    key = ~mask;
    repeat (2) @(negedge clk);
    key = 4'hF;
    @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    int budget = n * TC * 2 + 20;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (tick) seen++;
    end
    if (seen < n) check("tick_timeout", seen[15:0], n[15:0]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    do_reset();
    check("rst_disp", disp, 16'h0000);
    check("rst_running", running, 0);
    check("rst_lap", lap_active, 0);
    check("rst_tick", tick, 0);
    check("rst_alarm", alarm, 0);

    // start, ten ticks four cycles apart, then 00:10
    press(4'b0001);
    check("start_running", running, 1);
    prev = cyc;
    for (int i = 0; i < 10; i++) begin
      wait_ticks(1);
      check("tick_gap", 16'(cyc - prev), 16'(TC));
      prev = cyc;
    end
    @(negedge clk);
    check("run_10s", disp, 16'h0010);

    // start+clear in RUN pauses; tick at the pause edge still lands
    press(4'b0101);
    check("pause_running", running, 0);
    repeat (10) @(negedge clk);
    check("pause_hold", disp, 16'h0011);
    press(4'b0010);
    check("pause_lap_on", lap_active, 1);
    check("pause_lap_disp", disp, 16'h0011);
    press(4'b0100);
    check("clear_disp", disp, 16'h0000);
    check("clear_lap", lap_active, 0);
    check("clear_running", running, 0);

    // preset in IDLE, run across 59:59 wrap
    do_reset();
    press(4'b1000);
    check("preset_disp", disp, 16'h5900);
    check("preset_running", running, 0);
    press(4'b0001);
    wait_ticks(59);
    @(negedge clk);
    check("wrap_5959", disp, 16'h5959);
    wait_ticks(1);
    @(negedge clk);
    check("wrap_0000", disp, 16'h0000);
    wait_ticks(1);
    @(negedge clk);
    check("wrap_continue", disp, 16'h0001);
    press(4'b1000);
    check("preset_in_run", disp, 16'h0001);
    check("preset_in_run_state", running, 1);

    // start beats preset in IDLE
    do_reset();
    press(4'b1001);
    check("prio_start_preset_run", running, 1);
    check("prio_start_preset_disp", disp, 16'h0000);

    // lap freeze while live time advances
    do_reset();
    press(4'b0001);
    wait_ticks(2);
    press(4'b0010);
    check("lap_on", lap_active, 1);
    wait_ticks(3);
    @(negedge clk);
    check("lap_frozen", disp, 16'h0002);
    press(4'b0010);
    check("lap_off", lap_active, 0);
    check("lap_live", disp, 16'h0005);

    // alarm at 01:00 (constant 0 when the feature is not built)
    do_reset();
    press(4'b0001);
    wait_ticks(60);
    @(negedge clk);
    check("alarm_time", disp, 16'h0100);
    check("alarm_not_yet", alarm, 0);
    @(negedge clk);
    check("alarm_set", alarm, ALM_EXP);
    press(4'b0001);
    check("alarm_cleared", alarm, 0);
    check("alarm_pause", running, 0);

    // async reset mid-second in RUN
    do_reset();
    press(4'b0001);
    wait_ticks(2);
    press(4'b0010);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_disp", disp, 16'h0000);
    check("arst_running", running, 0);
    check("arst_lap", lap_active, 0);
    check("arst_tick", tick, 0);
    check("arst_alarm", alarm, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_idle", running, 0);
    check("post_rst_disp", disp, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
